// File: rtl/shift_pkg.sv
// Shared constants for the shift-register command sequencer: shifter mode codes and FSM state encoding.
package shift_pkg;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_LOAD  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? SH_LEFT : SH_RIGHT;
  endfunction

endpackage

// File: rtl/shift_cnt_down.sv
// Loadable down-counter holding the remaining shift count; flags zero and last-shift conditions.
module shift_cnt_down #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving an external bidirectional shift register: load, shift N times, present result.
// Optional rotate support is enabled by defining SHIFT_ROTATE_EN.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  output logic [1:0]       sh_s,
  output logic [WIDTH-1:0] sh_din,
  output logic             sh_srsi,
  output logic             sh_slsi,
  input  logic [WIDTH-1:0] sh_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_fill;

  logic w_accept;
  logic w_dec;
  logic w_cnt_zero;
  logic w_cnt_last;
  logic w_fill;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_dec    = (r_state == ST_SHIFT);

  shift_cnt_down #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .clr     (clr),
    .i_load  (w_accept),
    .i_value (cmd_cnt),
    .i_dec   (w_dec),
    .o_zero  (w_cnt_zero),
    .o_last  (w_cnt_last)
  );

  // Command fields are only sampled on the accept edge, so later changes on cmd_* are ignored.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_fill  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_data  <= cmd_data;
            r_dir   <= cmd_dir;
            r_fill  <= cmd_fill;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD:   r_state <= w_cnt_zero ? ST_RESULT : ST_SHIFT;
        ST_SHIFT:  if (w_cnt_last) r_state <= ST_RESULT;
        ST_RESULT: if (res_ready) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFT_ROTATE_EN
  logic r_rot;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rot <= 1'b0;
    end else if (w_accept) begin
      r_rot <= cmd_rot;
    end
  end

  // Rotation recirculates the bit falling off the far end of the shifter.
  assign w_fill = r_rot ? (r_dir ? sh_dout[WIDTH-1] : sh_dout[0]) : r_fill;
`else
  logic w_unused_rot;
  assign w_unused_rot = cmd_rot;
  assign w_fill       = r_fill;
`endif

  always_comb begin
    sh_s      = SH_HOLD;
    sh_din    = '0;
    sh_srsi   = 1'b0;
    sh_slsi   = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    case (r_state)
      ST_LOAD: begin
        sh_s   = SH_LOAD;
        sh_din = r_data;
      end
      ST_SHIFT: begin
        sh_s    = shift_mode(r_dir);
        sh_srsi = w_fill;
        sh_slsi = w_fill;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        res_data  = sh_dout;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign cmd_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl paired with a behavioural 8-bit shifter; timeline-based reference model.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic             cmd_rot;
  logic [1:0]       sh_s;
  logic [WIDTH-1:0] sh_din;
  logic             sh_srsi;
  logic             sh_slsi;
  logic [WIDTH-1:0] sh_q = '0;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .cmd_rot   (cmd_rot),
    .sh_s      (sh_s),
    .sh_din    (sh_din),
    .sh_srsi   (sh_srsi),
    .sh_slsi   (sh_slsi),
    .sh_dout   (sh_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // The 8-bit shift register the sequencer drives
  always @(posedge clk) begin
    case (sh_s)
      2'b01:   sh_q <= {sh_srsi, sh_q[7:1]};
      2'b10:   sh_q <= {sh_q[6:0], sh_slsi};
      2'b11:   sh_q <= sh_din;
      default: sh_q <= sh_q;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected result after cnt shift cycles, computed in closed form
  function automatic logic [7:0] closed_form(input logic [7:0] d, input bit dir, input int cnt,
                                             input bit fill, input bit rot);
    logic [15:0] w;
    int k;
    if (rot) begin
      k = cnt % 8;
      if (!dir) begin
        w = {d, d} >> k;
        return w[7:0];
      end
      w = {d, d} << k;
      return w[15:8];
    end
    if (cnt >= 8) return {8{fill}};
    if (!dir) begin
      w = {{8{fill}}, d} >> cnt;
      return w[7:0];
    end
    w = {d, {8{fill}}} << cnt;
    return w[15:8];
  endfunction

  // Reference model: time since acceptance determines what the outputs must be.
  bit         chk_en = 1'b0;
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  int         m_cnt  = 0;
  logic [7:0] m_data = '0;
  logic [7:0] m_val  = '0;
  bit         m_dir  = 1'b0;
  bit         m_fill = 1'b0;
  bit         m_rot  = 1'b0;

  function automatic bit m_fill_now();
    if (m_rot) return m_dir ? m_val[7] : m_val[0];
    return m_fill;
  endfunction

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_age == 1) m_val = m_data;
      else if (m_age < 2 + m_cnt) m_val = m_dir ? {m_val[6:0], m_fill_now()} : {m_fill_now(), m_val[7:1]};
    end
    if (clr) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_data = cmd_data;
        m_dir  = cmd_dir;
        m_cnt  = int'(cmd_cnt);
        m_fill = cmd_fill;
`ifdef SHIFT_ROTATE_EN
        m_rot  = cmd_rot;
`else
        m_rot  = 1'b0;
`endif
      end
    end else if (m_age >= 2 + m_cnt) begin
      if (res_ready) m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_s;
    logic [7:0] e_din;
    logic [7:0] e_rd;
    logic       e_fill;
    logic       e_rv;
    if (chk_en) begin
      e_s = 2'b00; e_din = '0; e_rd = '0; e_fill = 1'b0; e_rv = 1'b0;
      if (m_busy) begin
        if (m_age == 1) begin
          e_s = 2'b11; e_din = m_data;
        end else if (m_age < 2 + m_cnt) begin
          e_s = m_dir ? 2'b10 : 2'b01; e_fill = m_fill_now();
        end else begin
          e_rv = 1'b1; e_rd = closed_form(m_data, m_dir, m_cnt, m_fill, m_rot);
        end
      end
      chk("cmp_cmd_ready", cmd_ready, !m_busy);
      chk("cmp_busy", busy, m_busy);
      chk("cmp_sh_s", sh_s, e_s);
      chk("cmp_sh_din", sh_din, e_din);
      chk("cmp_srsi", sh_srsi, e_fill);
      chk("cmp_slsi", sh_slsi, e_fill);
      chk("cmp_res_valid", res_valid, e_rv);
      chk("cmp_res_data", res_data, e_rd);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issues one command from the current cycle and returns in the first RESULT cycle.
  task automatic do_cmd(input string name, input logic [7:0] d, input bit dir, input int cnt,
                        input bit fill, input bit rot, input logic [7:0] lit,
                        output int n_left, output bit not_busy);
    int a;
    int n;
    n_left = 0;
    not_busy = 1'b0;
    chk({name, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_cnt = CNT_W'(cnt); cmd_fill = fill; cmd_rot = rot;
    a = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom); cmd_dir = 1'($urandom); cmd_cnt = 4'($urandom);
    cmd_fill = 1'($urandom); cmd_rot = 1'($urandom);
    n = 0;
    while (!res_valid && n < 40) begin
      if (sh_s == 2'b10) n_left++;
      if (!busy || cmd_ready) not_busy = 1'b1;
      step();
      n++;
    end
    if (!busy || cmd_ready) not_busy = 1'b1;
    chk({name, "_latency"}, cyc - a, 2 + cnt);
    chk({name, "_data"}, res_data, lit);
  endtask

  initial begin
    int   nl;
    bit   nb;
    logic [7:0] snap;
    int   n;

    clr = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
    cmd_data = '0; cmd_dir = 1'b0; cmd_cnt = '0; cmd_fill = 1'b0; cmd_rot = 1'b0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sh_s", sh_s, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_sh_din", sh_din, 0);
    clr = 1'b0;
    step();

    do_cmd("t1", 8'hA5, 1'b0, 3, 1'b0, 1'b0, 8'h14, nl, nb);
    step();
    do_cmd("t2", 8'hA5, 1'b1, 2, 1'b1, 1'b0, 8'h97, nl, nb);
    chk("t2_left_cycles", nl, 2);
    step();
    do_cmd("t3", 8'h3C, 1'b0, 0, 1'b0, 1'b0, 8'h3C, nl, nb);
    step();
    do_cmd("t4", 8'hFF, 1'b0, 12, 1'b0, 1'b0, 8'h00, nl, nb);
    chk("t4_busy_throughout", nb, 0);
    step();

    // Result stall with a competing command waiting
    res_ready = 1'b0;
    do_cmd("t5", 8'h5A, 1'b0, 1, 1'b1, 1'b0, 8'hAD, nl, nb);
    snap = res_data;
    cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_dir = 1'b1; cmd_cnt = 4'd1; cmd_fill = 1'b0; cmd_rot = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_data", res_data, snap);
      chk("t5_hold_mode", sh_s, 0);
      chk("t5_hold_ready", cmd_ready, 0);
      step();
    end
    res_ready = 1'b1;
    chk("t5_release_valid", res_valid, 1);
    step();
    chk("t5_idle_ready", cmd_ready, 1);
    chk("t5_idle_valid", res_valid, 0);
    step();
    cmd_valid = 1'b0;
    chk("t5_second_load", sh_s, 2'b11);
    chk("t5_second_din", sh_din, 8'h5A);
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    chk("t5_second_data", res_data, 8'hB4);
    step();

    // Reset in the second shift cycle
    cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_dir = 1'b0; cmd_cnt = 4'd5; cmd_fill = 1'b1; cmd_rot = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("t6_in_shift", sh_s, 2'b01);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_sh_s", sh_s, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    step();

`ifdef SHIFT_ROTATE_EN
    do_cmd("t7", 8'h81, 1'b0, 1, 1'b0, 1'b1, 8'hC0, nl, nb);
`else
    do_cmd("t7", 8'h81, 1'b0, 1, 1'b0, 1'b1, 8'h40, nl, nb);
`endif
    step();

    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = 8'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_cnt   = 4'($urandom);
      cmd_fill  = 1'($urandom);
      cmd_rot   = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      step();
    end

    clr = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("end_idle", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
